encode8_rr_arbiter: RTL and testbench

- Sequential 8-to-3 encoder. It takes 8 independent request lines and returns the index of the served requester as a 3-bit binary code, plus a valid/ready handshake.
- Round-robin priority prevents starvation.
- Sits in the ALU/control path where several one-hot sources (e.g. game tile events) must be collapsed into a single index for the processor.
- Its registered one-hot output is the 3-to-8 decode of its own index.

---
 rtl/alu_pkg.sv | 12 +
 rtl/decode3bits.sv | 15 +
 rtl/rr_pick8.sv | 32 +++
 rtl/encode8_rr_arbiter.sv | 102 ++++++++++
 tb/tb_encode8_rr_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the round-robin index encoder.
package alu_pkg;

  localparam int ARB_N = 8;
  localparam int ARB_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decode3bits.sv
// 3-to-8 binary decoder with enable; all-zero output when disabled.
module decode3bits (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      y = 8'(1) << sel;
    end
  end

endmodule

// File: rtl/rr_pick8.sv
// Round-robin pick over an 8-bit mask: first set bit scanning ptr, ptr+1, ... with wrap.
module rr_pick8
  import alu_pkg::*;
(
  input  logic [ARB_N-1:0] mask,
  input  logic [ARB_W-1:0] ptr,
  output logic [ARB_W-1:0] idx,
  output logic             found,
  output logic             multi
);

  logic [2*ARB_N-1:0] dbl;
  logic [ARB_N-1:0]   rot;
  logic [ARB_W-1:0]   enc;

  always_comb begin
    // Rotating right by ptr puts requester ptr at bit 0, so a fixed
    // lowest-bit-first encoder yields round-robin order after re-adding ptr.
    dbl = {mask, mask};
    rot = ARB_N'(dbl >> ptr);
    enc = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = ARB_W'(i);
      end
    end
    idx   = enc + ptr;
    found = |mask;
    multi = |(mask & (mask - ARB_N'(1)));
  end

endmodule

// File: rtl/encode8_rr_arbiter.sv
// Sequential 8-to-3 round-robin encoder: registered index/one-hot grant with a
// valid/ready handshake and a combinational per-requester acknowledge.
module encode8_rr_arbiter
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [ARB_N-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ARB_W-1:0] out_index,
  output logic [ARB_N-1:0] out_onehot,
  output logic             out_multi,
  output logic [ARB_N-1:0] req_ack
);

  arb_state_e       state_q, state_d;
  logic [ARB_W-1:0] ptr_q, ptr_d;
  logic [ARB_W-1:0] index_q, index_d;
  logic [ARB_N-1:0] onehot_q, onehot_d;
  logic             multi_q, multi_d;

  logic [ARB_N-1:0] pick_mask;
  logic [ARB_W-1:0] pick_ptr;
  logic [ARB_W-1:0] pick_idx;
  logic             pick_found;
  logic             pick_multi;
  logic             handshake;

  assign out_valid  = (state_q == ST_GRANT);
  assign out_index  = index_q;
  assign out_onehot = onehot_q;
  assign out_multi  = multi_q;
  assign handshake  = out_valid & out_ready;
  assign req_ack    = {ARB_N{handshake}} & onehot_q;

  // onehot_q is zero in IDLE, so the same mask serves both states; in GRANT it
  // drops the bit being accepted for this evaluation only.
  assign pick_mask = req & ~onehot_q;
  assign pick_ptr  = out_valid ? (index_q + ARB_W'(1)) : ptr_q;

  rr_pick8 u_pick (
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found),
    .multi (pick_multi)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    index_d = index_q;
    multi_d = multi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          index_d = pick_idx;
          multi_d = pick_multi;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (out_ready) begin
          ptr_d = index_q + ARB_W'(1);
          if (pick_found) begin
            index_d = pick_idx;
            multi_d = pick_multi;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  decode3bits u_dec (
    .sel (index_d),
    .en  (state_d == ST_GRANT),
    .y   (onehot_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      index_q  <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      index_q  <= index_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
    end
  end

endmodule

// File: tb/tb_encode8_rr_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a scan-based reference model.
module tb_encode8_rr_arbiter;

  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_index;
  logic [7:0] out_onehot;
  logic       out_multi;
  logic [7:0] req_ack;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  bit m_multi;
  int m_ptr;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic [7:0] ack;
    logic       valid;
    logic [2:0] idx;
    logic       multi;
  } vec_t;

  vec_t tbl[14];

  encode8_rr_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_index  (out_index),
    .out_onehot (out_onehot),
    .out_multi  (out_multi),
    .req_ack    (req_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_pick(input logic [7:0] m, input int p, output int idx, output bit multi);
    idx = -1;
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (p + k) % 8;
      if (m[j] && idx < 0) idx = j;
    end
    multi = ($countones(m) >= 2);
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_multi = 1'b0;
    m_ptr   = 0;
  endfunction

  function automatic void model_step(input logic [7:0] r, input bit rdy);
    int  w;
    bit  mu;
    logic [7:0] mk;
    if (!m_valid) begin
      if (r != 8'h00) begin
        m_pick(r, m_ptr, w, mu);
        m_idx   = w;
        m_multi = mu;
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      m_ptr = (m_idx + 1) % 8;
      mk    = r & ~(8'(1) << m_idx);
      if (mk != 8'h00) begin
        m_pick(mk, m_ptr, w, mu);
        m_idx   = w;
        m_multi = mu;
      end else begin
        m_valid = 1'b0;
      end
    end
  endfunction

  function automatic logic [7:0] exp_onehot();
    return m_valid ? (8'(1) << m_idx) : 8'h00;
  endfunction

  // Drive inputs just after a falling edge, sample req_ack before the rising
  // edge, advance the model on the rising edge, return at the next falling edge.
  task automatic drive_cycle(input logic [7:0] r, input logic rdy, output logic [7:0] ack_seen);
    req       = r;
    out_ready = rdy;
    #1;
    ack_seen = req_ack;
    @(posedge clock);
    model_step(r, rdy);
    @(negedge clock);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"},  8'(out_valid),  8'(m_valid));
    check({tag, ".index"},  8'(out_index),  8'(m_idx));
    check({tag, ".onehot"}, out_onehot,     exp_onehot());
    check({tag, ".multi"},  8'(out_multi),  8'(m_multi));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req   = 8'h00;
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] ack;
    logic [7:0] eack;
    logic [7:0] r;
    logic       rdy;

    tbl[0]  = '{8'h24, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1};
    tbl[1]  = '{8'h24, 1'b1, 8'h04, 1'b1, 3'd5, 1'b0};
    tbl[2]  = '{8'h24, 1'b1, 8'h20, 1'b1, 3'd2, 1'b0};
    tbl[3]  = '{8'h24, 1'b1, 8'h04, 1'b1, 3'd5, 1'b0};
    tbl[4]  = '{8'h00, 1'b1, 8'h20, 1'b0, 3'd5, 1'b0};
    tbl[5]  = '{8'h41, 1'b0, 8'h00, 1'b1, 3'd6, 1'b1};
    tbl[6]  = '{8'h01, 1'b1, 8'h40, 1'b1, 3'd0, 1'b0};
    tbl[7]  = '{8'h00, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{8'h80, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd7, 1'b0};
    tbl[10] = '{8'h00, 1'b1, 8'h80, 1'b0, 3'd7, 1'b0};
    tbl[11] = '{8'h03, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1};
    tbl[12] = '{8'h03, 1'b1, 8'h01, 1'b1, 3'd1, 1'b0};
    tbl[13] = '{8'h00, 1'b1, 8'h02, 1'b0, 3'd1, 1'b0};

    // Reset state with all requests pending
    reset = 1'b1;
    req = 8'hFF;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst.valid",  8'(out_valid), 8'h00);
    check("rst.index",  8'(out_index), 8'h00);
    check("rst.onehot", out_onehot,    8'h00);
    check("rst.multi",  8'(out_multi), 8'h00);
    check("rst.ack",    req_ack,       8'h00);
    reset = 1'b0;
    drive_cycle(8'hFF, 1'b0, ack);
    check("first.valid",  8'(out_valid), 8'h01);
    check("first.index",  8'(out_index), 8'h00);
    check("first.onehot", out_onehot,    8'h01);
    check("first.multi",  8'(out_multi), 8'h01);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(8'hFF, 1'b0, ack);
      check("hold.index", 8'(out_index), 8'h00);
      check("hold.ack",   ack,           8'h00);
    end

    // Directed table from a fresh reset
    pulse_reset();
    for (int i = 0; i < 14; i++) begin
      drive_cycle(tbl[i].req, tbl[i].rdy, ack);
      check($sformatf("tbl%0d.ack", i),    ack,                tbl[i].ack);
      check($sformatf("tbl%0d.valid", i),  8'(out_valid),      8'(tbl[i].valid));
      check($sformatf("tbl%0d.index", i),  8'(out_index),      8'(tbl[i].idx));
      check($sformatf("tbl%0d.multi", i),  8'(out_multi),      8'(tbl[i].multi));
      check($sformatf("tbl%0d.onehot", i), out_onehot,
            tbl[i].valid ? (8'(1) << tbl[i].idx) : 8'h00);
    end

    // Asynchronous reset while index 3 is granted
    pulse_reset();
    drive_cycle(8'h08, 1'b0, ack);
    check("ar.pre_index", 8'(out_index), 8'h03);
    out_ready = 1'b1;
    #2;
    check("ar.pre_ack", req_ack, 8'h08);
    reset = 1'b1;
    #1;
    check("ar.valid",  8'(out_valid), 8'h00);
    check("ar.onehot", out_onehot,    8'h00);
    check("ar.ack",    req_ack,       8'h00);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive_cycle(8'h09, 1'b0, ack);
    check("ar.post_valid", 8'(out_valid), 8'h01);
    check("ar.post_index", 8'(out_index), 8'h00);
    check("ar.post_multi", 8'(out_multi), 8'h01);

    // Idle with ready asserted: nothing may move
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(8'h00, 1'b1, ack);
      check("idle.ack", ack, 8'h00);
      check_model("idle");
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rdy = 1'($urandom);
      eack = (m_valid && rdy) ? exp_onehot() : 8'h00;
      drive_cycle(r, rdy, ack);
      check("rnd.ack", ack, eack);
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
